// File: rtl/rx_frame_checker.sv
// Ethernet receive frame checker: CRC-32 residue and length check, FCS stripping, per-frame status.
// Define RX_MAC_FILTER_EN to drop frames whose DA is neither LOCAL_MAC nor broadcast.

module rx_frame_checker #(
    parameter int          MIN_FRAME = 64,
    parameter int          MAX_FRAME = 1518,
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_i,
    input  logic        byte_vld_i,
    input  logic        crs_dv,
    output logic [7:0]  data_o,
    output logic        valid_o,
    output logic        sof_o,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        err_crc,
    output logic        err_len,
    output logic [10:0] frame_len
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_END,
        S_DROP
    } state_t;

    localparam logic [10:0] LP_MIN     = 11'(MIN_FRAME);
    localparam logic [10:0] LP_MAX     = 11'(MAX_FRAME);
    localparam logic [10:0] LP_SAT     = 11'd2047;
    localparam logic [31:0] LP_RESIDUE = 32'hDEBB20E3;
`ifdef RX_MAC_FILTER_EN
    // Two extra stages hold DA[0..1] until the last DA byte has been compared.
    localparam int          LP_DEPTH   = 6;
    localparam logic [10:0] LP_START   = 11'd6;
`else
    localparam int          LP_DEPTH   = 4;
    localparam logic [10:0] LP_START   = 11'd4;
`endif

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_crc;
    logic [10:0] r_count;
    logic [7:0]  r_dl [LP_DEPTH];
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_sof;
    logic        r_done;
    logic        r_ok;
    logic        r_err_crc;
    logic        r_err_len;
    logic [10:0] r_len;

    logic        w_first;
    logic        w_accept;
    logic        w_drop_flag;
    logic [31:0] w_crc_next;
    logic [10:0] w_count_next;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign w_first      = (r_state == S_IDLE) && byte_vld_i && crs_dv;
    assign w_accept     = w_first || (byte_vld_i && ((r_state == S_RECV) || (r_state == S_DROP)));
    assign w_crc_next   = crc32_byte(w_first ? 32'hFFFFFFFF : r_crc, byte_i);
    assign w_count_next = w_first ? 11'd1 : ((r_count == LP_SAT) ? r_count : r_count + 11'd1);

`ifdef RX_MAC_FILTER_EN
    logic       r_match_local;
    logic       r_match_bcast;
    logic       r_dropped;
    logic       r_flush;
    logic [2:0] w_da_idx;
    logic [7:0] w_mac_byte;
    logic       w_local_hit;
    logic       w_bcast_hit;
    logic       w_da_ok;
    logic       w_decide;

    // Running DA comparison; the verdict is taken as DA byte 5 is accepted.
    always_comb begin
        w_da_idx   = w_first ? 3'd0 : r_count[2:0];
        w_mac_byte = 8'h00;
        case (w_da_idx)
            3'd0:    w_mac_byte = LOCAL_MAC[47:40];
            3'd1:    w_mac_byte = LOCAL_MAC[39:32];
            3'd2:    w_mac_byte = LOCAL_MAC[31:24];
            3'd3:    w_mac_byte = LOCAL_MAC[23:16];
            3'd4:    w_mac_byte = LOCAL_MAC[15:8];
            3'd5:    w_mac_byte = LOCAL_MAC[7:0];
            default: w_mac_byte = 8'h00;
        endcase
        w_local_hit = (byte_i == w_mac_byte) && (w_first || r_match_local);
        w_bcast_hit = (byte_i == 8'hFF) && (w_first || r_match_bcast);
        w_da_ok     = w_local_hit || w_bcast_hit;
        w_decide    = w_accept && !w_first && (r_count == 11'd5);
    end

    assign w_drop_flag = r_dropped;
`else
    logic w_unused_mac;
    assign w_unused_mac = ^LOCAL_MAC;
    assign w_drop_flag  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_first) begin
                    w_next_state = S_RECV;
                end
            end
            S_RECV: begin
                if (!crs_dv) begin
                    w_next_state = S_END;
                end
`ifdef RX_MAC_FILTER_EN
                else if (w_decide && !w_da_ok) begin
                    w_next_state = S_DROP;
                end
`endif
            end
            S_DROP: begin
                if (!crs_dv) begin
                    w_next_state = S_END;
                end
            end
            S_END:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Byte n entering the delay line pushes byte n-4 out; the last four (FCS) never leave.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_crc     <= 32'hFFFFFFFF;
            r_count   <= 11'd0;
            for (int i = 0; i < LP_DEPTH; i++) begin
                r_dl[i] <= 8'h00;
            end
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_sof     <= 1'b0;
            r_done    <= 1'b0;
            r_ok      <= 1'b0;
            r_err_crc <= 1'b0;
            r_err_len <= 1'b0;
            r_len     <= 11'd0;
`ifdef RX_MAC_FILTER_EN
            r_match_local <= 1'b0;
            r_match_bcast <= 1'b0;
            r_dropped     <= 1'b0;
            r_flush       <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_done  <= 1'b0;
`ifdef RX_MAC_FILTER_EN
            if (r_flush) begin
                r_data  <= r_dl[4];
                r_valid <= 1'b1;
                r_flush <= 1'b0;
            end
            if (w_first) begin
                r_dropped <= 1'b0;
            end
`endif
            if (w_accept) begin
                r_crc   <= w_crc_next;
                r_count <= w_count_next;
                r_dl[0] <= byte_i;
                for (int i = 1; i < LP_DEPTH; i++) begin
                    r_dl[i] <= r_dl[i-1];
                end
                if ((r_state == S_RECV) && (r_count >= LP_START) && (r_count < LP_MAX)) begin
                    r_data  <= r_dl[3];
                    r_valid <= 1'b1;
                    r_sof   <= (r_count == 11'd4);
                end
`ifdef RX_MAC_FILTER_EN
                if (w_first || (r_count < 11'd6)) begin
                    r_match_local <= w_local_hit;
                    r_match_bcast <= w_bcast_hit;
                end
                if (w_decide) begin
                    if (w_da_ok) begin
                        r_data  <= r_dl[4];
                        r_valid <= 1'b1;
                        r_sof   <= 1'b1;
                        r_flush <= 1'b1;
                    end else begin
                        r_dropped <= 1'b1;
                    end
                end
`endif
            end
            if (r_state == S_END) begin
                r_done    <= 1'b1;
                r_len     <= r_count;
                r_err_crc <= (r_crc != LP_RESIDUE);
                r_err_len <= (r_count < LP_MIN) || (r_count > LP_MAX);
                r_ok      <= (r_crc == LP_RESIDUE) && (r_count >= LP_MIN) &&
                             (r_count <= LP_MAX) && !w_drop_flag;
            end
        end
    end

    assign data_o     = r_data;
    assign valid_o    = r_valid;
    assign sof_o      = r_sof;
    assign frame_done = r_done;
    assign frame_ok   = r_ok;
    assign err_crc    = r_err_crc;
    assign err_len    = r_err_len;
    assign frame_len  = r_len;

endmodule

// File: tb/tb_rx_frame_checker.sv
// Scoreboard bench for rx_frame_checker: payload bytes and frame status are queued as frames are driven.
// Built with or without RX_MAC_FILTER_EN; the drop scenario is only exercised when the filter exists.

module tb_rx_frame_checker;

    localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  byte_i;
    logic        byte_vld_i;
    logic        crs_dv;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        sof_o;
    logic        frame_done;
    logic        frame_ok;
    logic        err_crc;
    logic        err_len;
    logic [10:0] frame_len;

    int n_chk   = 0;
    int n_pass  = 0;
    int n_done  = 0;
    int n_valid = 0;

    logic [8:0]  exp_q[$];
    logic [13:0] st_q[$];
    logic [7:0]  frame[];

    always #5 clk = ~clk;

    rx_frame_checker #(
        .MIN_FRAME(64),
        .MAX_FRAME(1518),
        .LOCAL_MAC(MAC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .byte_i(byte_i),
        .byte_vld_i(byte_vld_i),
        .crs_dv(crs_dv),
        .data_o(data_o),
        .valid_o(valid_o),
        .sof_o(sof_o),
        .frame_done(frame_done),
        .frame_ok(frame_ok),
        .err_crc(err_crc),
        .err_len(err_len),
        .frame_len(frame_len)
    );

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = {1'b0, c[31:1]};
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    // Scoreboard: pops one expected byte per valid_o and one expected status per frame_done.
    always @(negedge clk) begin
        logic [8:0]  e;
        logic [13:0] s;
        if (valid_o) begin
            n_valid++;
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL unexpected_valid: got data %02h sof %0b, required no output", data_o, sof_o);
            end else begin
                e = exp_q.pop_front();
                if ({sof_o, data_o} !== e) begin
                    $display("[TB] FAIL payload_byte: got sof/data %03h, required %03h", {sof_o, data_o}, e);
                end else begin
                    n_pass++;
                end
            end
        end else if (sof_o) begin
            n_chk++;
            $display("[TB] FAIL sof_without_valid: got sof_o=1, required 0");
        end
        if (frame_done) begin
            n_done++;
            n_chk++;
            if (st_q.size() == 0) begin
                $display("[TB] FAIL unexpected_done: got frame_done=1, required 0");
            end else begin
                s = st_q.pop_front();
                if ({frame_ok, err_crc, err_len, frame_len} !== s) begin
                    $display("[TB] FAIL frame_status: got ok/crc/len/len=%0b/%0b/%0b/%0d, required %0b/%0b/%0b/%0d",
                             frame_ok, err_crc, err_len, frame_len, s[13], s[12], s[11], s[10:0]);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic build_frame(input int len, input logic [47:0] da, input int flip);
        logic [31:0] c;
        frame = new[len];
        for (int i = 0; i < len; i++) begin
            if (i < 6) frame[i] = da[47-8*i -: 8];
            else       frame[i] = 8'($urandom);
        end
        if (len >= 10) begin
            c = 32'hFFFFFFFF;
            for (int i = 0; i < len - 4; i++) c = crc_step(c, frame[i]);
            c = ~c;
            frame[len-4] = c[7:0];
            frame[len-3] = c[15:8];
            frame[len-2] = c[23:16];
            frame[len-1] = c[31:24];
        end
        if (flip >= 0) frame[flip] = frame[flip] ^ 8'h10;
    endtask

    // Drives n_send bytes of frame[] at one strobe per 4 clocks; a full frame also queues its status.
    task automatic send_frame(input int len, input int n_send, input bit drop_exp, input bit fall_with_last);
        logic [31:0] c;
        logic        ce;
        logic        le;
        if (n_send == len) begin
            c = 32'hFFFFFFFF;
            for (int i = 0; i < len; i++) c = crc_step(c, frame[i]);
            ce = (c != 32'hDEBB20E3);
            le = (len < 64) || (len > 1518);
            st_q.push_back({!ce && !le && !drop_exp, ce, le, 11'(len)});
        end
        for (int n = 0; n < n_send; n++) begin
            @(negedge clk);
            crs_dv     = 1'b1;
            byte_i     = frame[n];
            byte_vld_i = 1'b1;
            if (!drop_exp && n >= 4 && (n - 4) < 1514) exp_q.push_back({n == 4, frame[n-4]});
            if (fall_with_last && n == len - 1) crs_dv = 1'b0;
            @(negedge clk);
            byte_vld_i = 1'b0;
            repeat (2) @(negedge clk);
        end
        if (n_send == len) crs_dv = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (st_q.size() == 0 && exp_q.size() == 0) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({data_o, valid_o, sof_o, frame_done, frame_ok, err_crc, err_len, frame_len} !== 26'd0) begin
            $display("[TB] FAIL reset_outputs: got %07h, required 0",
                     {data_o, valid_o, sof_o, frame_done, frame_ok, err_crc, err_len, frame_len});
        end else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_frame(input string name, input int len, input logic [47:0] da, input int flip,
                             input bit drop_exp, input bit fall, input int exp_valid,
                             input logic exp_ok, input logic exp_crc, input logic exp_len);
        int d0;
        d0      = n_done;
        n_valid = 0;
        build_frame(len, da, flip);
        send_frame(len, len, drop_exp, fall);
        wait_idle();
        n_chk++;
        if (n_valid !== exp_valid) $display("[TB] FAIL %s_valid_count: got %0d, required %0d", name, n_valid, exp_valid);
        else n_pass++;
        n_chk++;
        if (n_done - d0 !== 1) $display("[TB] FAIL %s_done_count: got %0d, required 1", name, n_done - d0);
        else n_pass++;
        n_chk++;
        if ({frame_ok, err_crc, err_len, frame_len} !== {exp_ok, exp_crc, exp_len, 11'(len)}) begin
            $display("[TB] FAIL %s_flags: got ok/crc/len/len=%0b/%0b/%0b/%0d, required %0b/%0b/%0b/%0d",
                     name, frame_ok, err_crc, err_len, frame_len, exp_ok, exp_crc, exp_len, len);
        end else n_pass++;
    endtask

    task automatic test_good_frame();   run_frame("good",   64,   MAC, -1, 0, 0, 60,   1, 0, 0); endtask
    task automatic test_bad_crc();      run_frame("badcrc", 64,   MAC, 20, 0, 0, 60,   0, 1, 0); endtask
    task automatic test_short_frame();  run_frame("short",  40,   MAC, -1, 0, 0, 36,   0, 0, 1); endtask
    task automatic test_long_frame();   run_frame("long",   1600, MAC, -1, 0, 0, 1514, 0, 0, 1); endtask
    task automatic test_max_frame();    run_frame("max",    1518, MAC, -1, 0, 0, 1514, 1, 0, 0); endtask
    task automatic test_same_cycle_fall(); run_frame("fall", 64,  MAC, -1, 0, 1, 60,   1, 0, 0); endtask

    task automatic test_tiny_frame();
        int d0;
        d0      = n_done;
        n_valid = 0;
        build_frame(3, MAC, -1);
        send_frame(3, 3, 0, 0);
        wait_idle();
        n_chk++;
        if (n_valid !== 0) $display("[TB] FAIL tiny_valid_count: got %0d, required 0", n_valid);
        else n_pass++;
        n_chk++;
        if ({n_done - d0, err_len, frame_ok, frame_len} !== {32'd1, 1'b1, 1'b0, 11'd3}) begin
            $display("[TB] FAIL tiny_status: got done=%0d err_len=%0b ok=%0b len=%0d, required 1/1/0/3",
                     n_done - d0, err_len, frame_ok, frame_len);
        end else n_pass++;
    endtask

    task automatic test_zero_frame();
        int d0;
        d0 = n_done;
        @(negedge clk);
        crs_dv = 1'b1;
        repeat (6) @(negedge clk);
        crs_dv = 1'b0;
        repeat (20) @(negedge clk);
        n_chk++;
        if (n_done !== d0) $display("[TB] FAIL zero_frame_done: got %0d dones, required 0", n_done - d0);
        else n_pass++;
    endtask

    task automatic test_ignored_bytes();
        int d0;
        d0      = n_done;
        n_valid = 0;
        crs_dv  = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            byte_i     = 8'(n + 8'hA0);
            byte_vld_i = 1'b1;
            @(negedge clk);
            byte_vld_i = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        n_chk++;
        if ({n_done - d0, n_valid} !== {32'd0, 32'd0}) begin
            $display("[TB] FAIL ignored_bytes: got done=%0d valid=%0d, required 0/0", n_done - d0, n_valid);
        end else n_pass++;
    endtask

    task automatic test_mac_filter();
`ifdef RX_MAC_FILTER_EN
        run_frame("drop",  64, 48'h00_11_22_33_44_55, -1, 1, 0, 0,  0, 0, 0);
`else
        run_frame("nofilt", 64, 48'h00_11_22_33_44_55, -1, 0, 0, 60, 1, 0, 0);
`endif
        run_frame("bcast", 64, BCAST, -1, 0, 0, 60, 1, 0, 0);
    endtask

    task automatic test_midframe_reset();
        int d0;
        d0 = n_done;
        build_frame(64, MAC, -1);
        send_frame(64, 30, 0, 0);
        @(negedge clk);
        byte_i     = frame[30];
        byte_vld_i = 1'b1;
        rst_n      = 1'b0;
        @(negedge clk);
        byte_vld_i = 1'b0;
        n_chk++;
        if ({data_o, valid_o, sof_o, frame_done, frame_ok, err_crc, err_len, frame_len} !== 26'd0) begin
            $display("[TB] FAIL midreset_outputs: got %07h, required 0",
                     {data_o, valid_o, sof_o, frame_done, frame_ok, err_crc, err_len, frame_len});
        end else n_pass++;
        rst_n  = 1'b1;
        crs_dv = 1'b0;
        repeat (20) @(negedge clk);
        n_chk++;
        if ({n_done - d0, 32'(exp_q.size())} !== {32'd0, 32'd0}) begin
            $display("[TB] FAIL midreset_abandon: got done=%0d pending=%0d, required 0/0", n_done - d0, exp_q.size());
        end else n_pass++;
        run_frame("postreset", 64, MAC, -1, 0, 0, 60, 1, 0, 0);
    endtask

    task automatic test_back_to_back();
        int d0;
        d0      = n_done;
        n_valid = 0;
        build_frame(64, MAC, -1);
        send_frame(64, 64, 0, 0);
        repeat (48) @(negedge clk);
        build_frame(70, BCAST, 33);
        send_frame(70, 70, 0, 0);
        wait_idle();
        n_chk++;
        if ({n_done - d0, n_valid} !== {32'd2, 32'd126}) begin
            $display("[TB] FAIL b2b_counts: got done=%0d valid=%0d, required 2/126", n_done - d0, n_valid);
        end else n_pass++;
        n_chk++;
        if ({frame_ok, err_crc, frame_len} !== {1'b0, 1'b1, 11'd70}) begin
            $display("[TB] FAIL b2b_second_status: got ok=%0b crc=%0b len=%0d, required 0/1/70", frame_ok, err_crc, frame_len);
        end else n_pass++;
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        byte_i     = 8'h00;
        byte_vld_i = 1'b0;
        crs_dv     = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_short_frame();
        test_tiny_frame();
        test_zero_frame();
        test_ignored_bytes();
        test_same_cycle_fall();
        test_mac_filter();
        test_midframe_reset();
        test_back_to_back();
        test_long_frame();
        test_max_frame();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
